// File: rtl/pipe_ctrl.sv
// pipe_ctrl: 5-stage pipeline sequencer for stalls, redirect squashes, halt drain and perf counters.
module pipe_ctrl #(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       ifid_rs,
    input  logic [2:0]       ifid_rt,
    input  logic             ifid_usesRs,
    input  logic             ifid_usesRt,
    input  logic             idex_memRead,
    input  logic             idex_regWrite,
    input  logic [2:0]       idex_writereg,
    input  logic             exmem_redirect,
    input  logic             halt_id,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             err
);
    typedef enum logic [1:0] {RUN = 2'b00, DRAIN = 2'b01, HALTED = 2'b10} state_t;
    state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;
    logic err_q, err_d, stall_inc, flush_inc, err_set, load_use;
    logic pc_en_c, ifid_en_c, ifid_fl_c, idex_fl_c, exmem_fl_c;
    assign load_use = idex_memRead & idex_regWrite &
                      ((ifid_usesRs & (ifid_rs == idex_writereg)) |
                       (ifid_usesRt & (ifid_rt == idex_writereg)));
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pc_en_c    = 1'b1;
        ifid_en_c  = 1'b1;
        ifid_fl_c  = 1'b0;
        idex_fl_c  = 1'b0;
        exmem_fl_c = 1'b0;
        stall_inc  = 1'b0;
        flush_inc  = 1'b0;
        err_set    = 1'b0;
        case (state_q)
            RUN: begin
                if (exmem_redirect) begin
                    ifid_fl_c  = 1'b1;
                    idex_fl_c  = 1'b1;
                    exmem_fl_c = 1'b1;
                    flush_inc  = 1'b1;
                end else if (load_use) begin
                    pc_en_c   = 1'b0;
                    ifid_en_c = 1'b0;
                    idex_fl_c = 1'b1;
                    stall_inc = 1'b1;
                end else if (halt_id) begin
                    pc_en_c   = 1'b0;
                    ifid_fl_c = 1'b1;
                    state_d   = DRAIN;
                    cnt_d     = 4'(DRAIN_CYCLES - 1);
                end
            end
            DRAIN: begin
                pc_en_c   = 1'b0;
                ifid_fl_c = 1'b1;
                // a redirect here means the halt itself was on the wrong path
                if (exmem_redirect) begin
                    pc_en_c    = 1'b1;
                    idex_fl_c  = 1'b1;
                    exmem_fl_c = 1'b1;
                    flush_inc  = 1'b1;
                    state_d    = RUN;
                end else if (cnt_q == 4'd0) begin
                    state_d = HALTED;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            HALTED: begin
                pc_en_c   = 1'b0;
                ifid_en_c = 1'b0;
                err_set   = exmem_redirect | halt_id;
            end
            default: begin
                err_set = 1'b1;
                state_d = RUN;
            end
        endcase
        stall_d = (stall_inc && !(&stall_q)) ? stall_q + CNT_W'(1) : stall_q;
        flush_d = (flush_inc && !(&flush_q)) ? flush_q + CNT_W'(1) : flush_q;
        err_d   = err_q | err_set;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= RUN;
            cnt_q   <= 4'd0;
            stall_q <= '0;
            flush_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
            err_q   <= err_d;
        end
    end
    assign pc_en       = !rst | pc_en_c;
    assign ifid_en     = !rst | ifid_en_c;
    assign ifid_flush  = rst & ifid_fl_c;
    assign idex_flush  = rst & idex_fl_c;
    assign exmem_flush = rst & exmem_fl_c;
    assign halted      = (state_q == HALTED);
    assign stall_cnt   = stall_q;
    assign flush_cnt   = flush_q;
    assign err         = err_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed self-checking bench for pipe_ctrl.
module tb_pipe_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  ifid_rs, ifid_rt, idex_writereg;
    logic        ifid_usesRs, ifid_usesRt, idex_memRead, idex_regWrite;
    logic        exmem_redirect, halt_id;
    logic        pc_en, ifid_en, ifid_flush, idex_flush, exmem_flush, halted, err;
    logic [15:0] stall_cnt, flush_cnt;
    int          n_vec = 0;
    int          n_bad = 0;

    pipe_ctrl #(.DRAIN_CYCLES(3), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
        .ifid_usesRs(ifid_usesRs), .ifid_usesRt(ifid_usesRt),
        .idex_memRead(idex_memRead), .idex_regWrite(idex_regWrite),
        .idex_writereg(idex_writereg), .exmem_redirect(exmem_redirect),
        .halt_id(halt_id), .pc_en(pc_en), .ifid_en(ifid_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmem_flush(exmem_flush), .halted(halted),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ifid_rs = 3'd0; ifid_rt = 3'd0; idex_writereg = 3'd0;
        ifid_usesRs = 1'b0; ifid_usesRt = 1'b0;
        idex_memRead = 1'b0; idex_regWrite = 1'b0;
        exmem_redirect = 1'b0; halt_id = 1'b0;
        #1;
    endtask

    task automatic load_r3(input logic uses_rs);
        idex_memRead = 1'b1; idex_regWrite = 1'b1; idex_writereg = 3'd3;
        ifid_rs = 3'd3; ifid_usesRs = uses_rs; ifid_rt = 3'd5; ifid_usesRt = 1'b1;
        #1;
    endtask

    initial begin
        rst = 1'b0;
        idle();
        tick(1);
        chk("rst_pc_en", pc_en, 1);
        chk("rst_ifid_en", ifid_en, 1);
        chk("rst_flushes", {ifid_flush, idex_flush, exmem_flush}, 0);
        chk("rst_stall", stall_cnt, 0);
        chk("rst_flushcnt", flush_cnt, 0);
        chk("rst_halted_err", {halted, err}, 0);
        rst = 1'b1;
        tick(1);

        load_r3(1'b1);
        chk("lu_pc_en", pc_en, 0);
        chk("lu_ifid_en", ifid_en, 0);
        chk("lu_idex_flush", idex_flush, 1);
        chk("lu_other_flush", {ifid_flush, exmem_flush}, 0);
        tick(1);
        idle();
        chk("lu_next_pc_en", pc_en, 1);
        chk("lu_stall_cnt", stall_cnt, 1);
        load_r3(1'b0);
        chk("nolu_pc_en", pc_en, 1);
        chk("nolu_idex_flush", idex_flush, 0);
        tick(1);
        idle();
        chk("nolu_stall_cnt", stall_cnt, 1);

        load_r3(1'b1);
        exmem_redirect = 1'b1; halt_id = 1'b1;
        #1;
        chk("redir_flushes", {ifid_flush, idex_flush, exmem_flush}, 3'b111);
        chk("redir_pc_en", pc_en, 1);
        tick(1);
        idle();
        chk("redir_flush_cnt", flush_cnt, 1);
        chk("redir_stall_cnt", stall_cnt, 1);
        chk("redir_in_run", {pc_en, ifid_en, ifid_flush, halted}, 4'b1100);

        halt_id = 1'b1;
        #1;
        chk("halt_pc_en", pc_en, 0);
        chk("halt_flushes", {ifid_flush, idex_flush, exmem_flush}, 3'b100);
        tick(1);
        idle();
        for (int i = 0; i < 3; i++) begin
            chk("drain_pc_en", pc_en, 0);
            chk("drain_ifid", {ifid_en, ifid_flush}, 2'b11);
            chk("drain_halted", halted, 0);
            tick(1);
        end
        for (int i = 0; i < 20; i++) begin
            chk("halted_hold", halted, 1);
            chk("halted_ctl", {pc_en, ifid_en, ifid_flush, idex_flush, exmem_flush}, 0);
            chk("halted_err0", err, 0);
            tick(1);
        end

        exmem_redirect = 1'b1;
        #1;
        chk("hredir_no_flush", {ifid_flush, idex_flush, exmem_flush}, 0);
        tick(1);
        idle();
        chk("hredir_err", err, 1);
        chk("hredir_halted", halted, 1);
        chk("hredir_flush_cnt", flush_cnt, 1);
        tick(3);
        chk("err_sticky", err, 1);
        rst = 1'b0;
        #1;
        chk("rstlow_pc_en", pc_en, 1);
        tick(1);
        rst = 1'b1;
        #1;
        chk("rst2_halted_err", {halted, err}, 0);
        chk("rst2_counters", {stall_cnt, flush_cnt}, 0);
        chk("rst2_pc_en", pc_en, 1);

        halt_id = 1'b1;
        tick(1);
        idle();
        load_r3(1'b1);
        chk("drain_lu_ignored", {pc_en, ifid_en, idex_flush}, 3'b010);
        tick(1);
        idle();
        exmem_redirect = 1'b1;
        #1;
        chk("dredir_flushes", {ifid_flush, idex_flush, exmem_flush}, 3'b111);
        chk("dredir_pc_en", pc_en, 1);
        tick(1);
        idle();
        chk("dredir_run", {pc_en, ifid_flush, halted}, 3'b100);
        chk("dredir_flush_cnt", flush_cnt, 1);
        chk("dredir_stall_cnt", stall_cnt, 0);
        tick(5);
        chk("dredir_never_halt", halted, 0);

        halt_id = 1'b1;
        tick(4);
        idle();
        chk("halt2_halted", halted, 1);
        halt_id = 1'b1;
        tick(1);
        idle();
        chk("halt_in_halted_err", err, 1);
        rst = 1'b0;
        tick(1);
        rst = 1'b1;
        #1;

        load_r3(1'b1);
        tick(65534);
        chk("sat_fffe", stall_cnt, 16'hFFFE);
        tick(1);
        chk("sat_ffff", stall_cnt, 16'hFFFF);
        tick(2);
        chk("sat_nowrap", stall_cnt, 16'hFFFF);
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
